cellrv32_gpio_filter: RTL and testbench

- Input-conditioning stage between the physical input pins and the GPIO input port.
- Synchronizes raw pins and optionally debounces them with a shared prescaled tick. Drives the clean vector into the GPIO block's gpio_i.
- Detects rising/falling edges on the filtered vector and raises a level interrupt to the CPU. Control/status through a small word-addressed bus slave using the processor's standard rden/wren/ack handshake.

---
 rtl/cellrv32_gpio_filter.sv | 178 +++++++++++++++++
 tb/tb_cellrv32_gpio_filter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_gpio_filter.sv
// Input conditioning for the GPIO port: two-flop synchronizer, prescaled debounce filter,
// rise/fall edge detection with sticky pending flags and a level interrupt.
module cellrv32_gpio_filter #(
    parameter int          GPIO_NUM  = 64,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFC00,
    parameter int          DEB_TICKS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    input  logic [63:0] pins_i,
    output logic [63:0] gpio_f_o,
    output logic        irq_o
);

    localparam logic [63:0] PIN_MASK = (GPIO_NUM >= 64) ? {64{1'b1}} :
                                       ((64'd1 << GPIO_NUM) - 64'd1);
    localparam logic [3:0]  DEB_MAX  = 4'(DEB_TICKS - 1);

    // Bus handshake: rden_i/wren_i are single-cycle strobes qualified by the window decode;
    // ack_o follows one cycle later, with data_o valid in that same cycle for reads only.
    // A cycle with both strobes performs the write and returns the pre-write register value.
    logic        acc;
    logic [2:0]  widx;
    logic        wr_en;
    logic        ctrl_we;
    logic [31:0] rdata;
    logic        unused_addr_lsb;

    logic [15:0] prsc;
    logic        fen;
    logic [63:0] rise_en;
    logic [63:0] fall_en;
    logic [63:0] pend;
    logic [63:0] w1c;

    logic [15:0] prsc_cnt;
    logic        tick;

    logic [63:0] sync1;
    logic [63:0] sync2;
    logic [63:0] filt;
    logic [63:0] filt_d;
    logic [3:0]  cnt [64];
    logic [63:0] rise;
    logic [63:0] fall;

    assign acc             = (addr_i[31:5] == BASE_ADDR[31:5]);
    assign widx            = addr_i[4:2];
    assign wr_en           = acc & wren_i;
    assign ctrl_we         = wr_en & (widx == 3'd0);
    assign unused_addr_lsb = ^addr_i[1:0];

    always_comb begin
        rdata = '0;
        case (widx)
            3'd0:    rdata = {fen, 15'd0, prsc};
            3'd1:    rdata = rise_en[31:0];
            3'd2:    rdata = rise_en[63:32];
            3'd3:    rdata = fall_en[31:0];
            3'd4:    rdata = fall_en[63:32];
            3'd5:    rdata = pend[31:0];
            3'd6:    rdata = pend[63:32];
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            ack_o  <= acc & (rden_i | wren_i);
            data_o <= (acc & rden_i) ? rdata : 32'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prsc    <= '0;
            fen     <= 1'b0;
            rise_en <= '0;
            fall_en <= '0;
        end else if (wr_en) begin
            case (widx)
                3'd0: begin
                    prsc <= data_i[15:0];
                    fen  <= data_i[31];
                end
                3'd1:    rise_en[31:0]  <= data_i & PIN_MASK[31:0];
                3'd2:    rise_en[63:32] <= data_i & PIN_MASK[63:32];
                3'd3:    fall_en[31:0]  <= data_i & PIN_MASK[31:0];
                3'd4:    fall_en[63:32] <= data_i & PIN_MASK[63:32];
                default: ;
            endcase
        end
    end

    always_comb begin
        w1c = '0;
        if (wr_en && (widx == 3'd5)) w1c[31:0]  = data_i;
        if (wr_en && (widx == 3'd6)) w1c[63:32] = data_i;
    end

    // Shared debounce time base; rewriting CTRL restarts the period.
    assign tick = fen & (prsc_cnt == prsc);

    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_we || !fen) begin
            prsc_cnt <= '0;
        end else if (tick) begin
            prsc_cnt <= '0;
        end else begin
            prsc_cnt <= prsc_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins_i & PIN_MASK;
            sync2 <= sync1;
        end
    end

    // A pin must disagree with the filtered value on DEB_TICKS consecutive ticks to flip it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt <= '0;
            for (int i = 0; i < 64; i++) cnt[i] <= '0;
        end else if (!fen) begin
            filt <= sync2;
            for (int i = 0; i < 64; i++) cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < 64; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_MAX) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_d <= '0;
        end else begin
            filt_d <= filt;
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

    // New edges are ORed in after the clear so a same-cycle set survives the W1C.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend <= '0;
        end else begin
            pend <= ((pend & ~w1c) | (rise & rise_en) | (fall & fall_en)) & PIN_MASK;
        end
    end

    assign gpio_f_o = filt;
    assign irq_o    = |pend;

endmodule

// File: tb/tb_cellrv32_gpio_filter.sv
// Directed bench for cellrv32_gpio_filter: register-map vector table plus hand-written
// sequences for latency, debounce, W1C priority and mid-operation reset.
module tb_cellrv32_gpio_filter;

    localparam int          GPIO_NUM  = 40;
    localparam logic [31:0] BASE      = 32'hFFFFFC00;
    localparam int          DEB_TICKS = 4;

    localparam logic [31:0] A_CTRL    = BASE + 32'h00;
    localparam logic [31:0] A_REN_LO  = BASE + 32'h04;
    localparam logic [31:0] A_REN_HI  = BASE + 32'h08;
    localparam logic [31:0] A_FEN_LO  = BASE + 32'h0C;
    localparam logic [31:0] A_FEN_HI  = BASE + 32'h10;
    localparam logic [31:0] A_PEND_LO = BASE + 32'h14;
    localparam logic [31:0] A_PEND_HI = BASE + 32'h18;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic        rden_i;
    logic        wren_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic [63:0] pins_i;
    logic [63:0] gpio_f_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [4:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    cellrv32_gpio_filter #(
        .GPIO_NUM (GPIO_NUM),
        .BASE_ADDR(BASE),
        .DEB_TICKS(DEB_TICKS)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .addr_i  (addr_i),
        .rden_i  (rden_i),
        .wren_i  (wren_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .ack_o   (ack_o),
        .pins_i  (pins_i),
        .gpio_f_o(gpio_f_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        addr_i = addr;
        data_i = data;
        wren_i = 1'b1;
        @(posedge clk); #1;
        wren_i = 1'b0;
        check("wr_ack", ack_o, 1);
        check("wr_data_zero", data_o, 0);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        addr_i = addr;
        rden_i = 1'b1;
        @(posedge clk); #1;
        rden_i = 1'b0;
        check({name, "_ack"}, ack_o, 1);
        check(name, data_o, exp_q.pop_front());
    endtask

    task automatic add_vec(input logic wr, input logic [4:0] off, input logic [31:0] wdata,
                           input logic [31:0] exp);
        vec_t v;
        v.wr    = wr;
        v.off   = off;
        v.wdata = wdata;
        v.exp   = exp;
        vecs.push_back(v);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        logic seen;

        rst_i  = 1'b1;
        addr_i = '0;
        rden_i = 1'b0;
        wren_i = 1'b0;
        data_i = '0;
        pins_i = '0;
        cycles(3);
        rst_i = 1'b0;
        check("rst_gpio", gpio_f_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_ack", ack_o, 0);
        check("rst_data", data_o, 0);

        // Register map vectors (offset, write data, expected read)
        add_vec(1'b0, 5'h00, 32'h0,        32'h0);
        add_vec(1'b0, 5'h14, 32'h0,        32'h0);
        add_vec(1'b1, 5'h08, 32'hFFFFFFFF, 32'h0);
        add_vec(1'b0, 5'h08, 32'h0,        32'h000000FF);
        add_vec(1'b1, 5'h04, 32'hFFFFFFFF, 32'h0);
        add_vec(1'b0, 5'h04, 32'h0,        32'hFFFFFFFF);
        add_vec(1'b1, 5'h0C, 32'h12345678, 32'h0);
        add_vec(1'b0, 5'h0C, 32'h0,        32'h12345678);
        add_vec(1'b1, 5'h10, 32'hABCDEF01, 32'h0);
        add_vec(1'b0, 5'h10, 32'h0,        32'h00000001);
        add_vec(1'b1, 5'h00, 32'h7FFF1234, 32'h0);
        add_vec(1'b0, 5'h00, 32'h0,        32'h00001234);
        add_vec(1'b1, 5'h00, 32'h80000005, 32'h0);
        add_vec(1'b0, 5'h00, 32'h0,        32'h80000005);
        add_vec(1'b1, 5'h1C, 32'hFFFFFFFF, 32'h0);
        add_vec(1'b0, 5'h1C, 32'h0,        32'h0);
        add_vec(1'b1, 5'h14, 32'hFFFFFFFF, 32'h0);
        add_vec(1'b0, 5'h14, 32'h0,        32'h0);
        add_vec(1'b1, 5'h00, 32'h0,        32'h0);
        add_vec(1'b1, 5'h04, 32'h0,        32'h0);
        add_vec(1'b1, 5'h08, 32'h0,        32'h0);
        add_vec(1'b1, 5'h0C, 32'h0,        32'h0);
        add_vec(1'b1, 5'h10, 32'h0,        32'h0);
        add_vec(1'b0, 5'h04, 32'h0,        32'h0);
        add_vec(1'b0, 5'h10, 32'h0,        32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) bus_write(BASE + {27'd0, vecs[i].off}, vecs[i].wdata);
            else bus_read(BASE + {27'd0, vecs[i].off}, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Simultaneous read+write: write happens, old value returned
        @(posedge clk); #1;
        addr_i = A_CTRL; data_i = 32'h0000ABCD; rden_i = 1'b1; wren_i = 1'b1;
        @(posedge clk); #1;
        rden_i = 1'b0; wren_i = 1'b0;
        check("rdwr_ack", ack_o, 1);
        check("rdwr_old_data", data_o, 32'h0);
        bus_read(A_CTRL, 32'h0000ABCD, "rdwr_new_data");
        cycles(1);
        check("ack_drop", ack_o, 0);
        check("data_drop", data_o, 0);
        bus_write(A_CTRL, 32'h0);

        // Accesses outside the window
        @(posedge clk); #1;
        addr_i = BASE + 32'h20; rden_i = 1'b1;
        @(posedge clk); #1;
        rden_i = 1'b0;
        check("oow_hi_ack", ack_o, 0);
        check("oow_hi_data", data_o, 0);
        @(posedge clk); #1;
        addr_i = 32'h00000004; wren_i = 1'b1; data_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        wren_i = 1'b0;
        check("oow_lo_ack", ack_o, 0);
        bus_read(A_REN_LO, 32'h0, "oow_no_write");

        // Unused pins forced low in bypass
        pins_i = '1;
        cycles(3);
        check("unused_pins", gpio_f_o, 64'h000000FF_FFFFFFFF);
        pins_i = '0;
        cycles(4);
        check("pins_cleared", gpio_f_o, 0);

        // Bypass latency on pin 5 and rise pending
        bus_write(A_REN_LO, 32'h20);
        pins_i[5] = 1'b1;
        cycles(1);
        check("byp_e1", gpio_f_o[5], 0);
        cycles(1);
        check("byp_e2", gpio_f_o[5], 0);
        cycles(1);
        check("byp_e3", gpio_f_o[5], 1);
        check("byp_e3_irq", irq_o, 0);
        cycles(1);
        check("byp_e4_irq", irq_o, 1);
        bus_read(A_PEND_LO, 32'h20, "byp_pend");
        bus_write(A_PEND_LO, 32'h20);
        check("byp_clr_irq", irq_o, 0);
        bus_write(A_REN_LO, 32'h0);
        pins_i[5] = 1'b0;
        cycles(5);

        // Debounce reject: 10-cycle glitch, tick every 4 cycles
        bus_write(A_CTRL, 32'h80000003);
        bus_write(A_REN_LO, 32'h1);
        bus_write(A_FEN_LO, 32'h1);
        seen = 1'b0;
        pins_i[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            seen = seen | gpio_f_o[0];
        end
        pins_i[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycles(1);
            seen = seen | gpio_f_o[0];
        end
        check("rej_filt", seen, 0);
        bus_read(A_PEND_LO, 32'h0, "rej_pend");
        check("rej_irq", irq_o, 0);
        bus_write(A_REN_LO, 32'h0);

        // Debounce accept: stable high flips after 4 ticks (edges 15..18 after change)
        pins_i[0] = 1'b1;
        n = 0;
        do begin
            cycles(1);
            n++;
        end while (!gpio_f_o[0] && n < 30);
        check("acc_rise", gpio_f_o[0], 1);
        check("acc_rise_window", (n >= 15 && n <= 22), 1);
        bus_read(A_PEND_LO, 32'h0, "acc_no_rise_pend");
        pins_i[0] = 1'b0;
        n = 0;
        do begin
            cycles(1);
            n++;
        end while (gpio_f_o[0] && n < 30);
        check("acc_fall", gpio_f_o[0], 0);
        check("acc_fall_window", (n >= 15 && n <= 22), 1);
        check("acc_fall_irq_same", irq_o, 0);
        cycles(1);
        check("acc_fall_irq", irq_o, 1);
        bus_read(A_PEND_LO, 32'h1, "acc_fall_pend");
        bus_write(A_PEND_LO, 32'h1);
        check("acc_clr_irq", irq_o, 0);
        bus_write(A_FEN_LO, 32'h0);
        bus_write(A_CTRL, 32'h0);

        // W1C versus same-cycle set on pin 32
        bus_write(A_REN_HI, 32'h1);
        pins_i[32] = 1'b1;
        cycles(5);
        check("w1c_irq_set", irq_o, 1);
        bus_read(A_PEND_HI, 32'h1, "w1c_pend_set");
        pins_i[32] = 1'b0;
        cycles(5);
        pins_i[32] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus_write(A_PEND_HI, 32'h1);
        bus_read(A_PEND_HI, 32'h1, "w1c_set_wins");
        bus_write(A_PEND_HI, 32'h1);
        check("w1c_irq_clr", irq_o, 0);
        bus_read(A_PEND_HI, 32'h0, "w1c_cleared");

        // Clearing an enable keeps pending bits
        bus_write(A_FEN_HI, 32'h1);
        pins_i[32] = 1'b0;
        cycles(5);
        check("en_clr_irq_pre", irq_o, 1);
        bus_write(A_FEN_HI, 32'h0);
        bus_read(A_PEND_HI, 32'h1, "en_clr_keeps_pend");

        // Reset mid-debounce with pending set
        bus_write(A_CTRL, 32'h80000003);
        pins_i[0] = 1'b1;
        cycles(8);
        rst_i = 1'b1;
        cycles(1);
        rst_i = 1'b0;
        check("mrst_gpio", gpio_f_o, 0);
        check("mrst_irq", irq_o, 0);
        check("mrst_ack", ack_o, 0);
        bus_read(A_CTRL, 32'h0, "mrst_ctrl");
        bus_read(A_PEND_HI, 32'h0, "mrst_pend");
        bus_read(A_REN_HI, 32'h0, "mrst_ren");
        check("mrst_bypass", gpio_f_o[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
